// File: rtl/shift_reg_74194_ctrl.sv
// Command sequencer for one 4-bit 74194-style bidirectional shift register.
// Accepts one operation at a time over valid/ready. It steps the register
// through the operation on the shared clock, then reports the final Q.
module shift_reg_74194_ctrl (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [2:0] CMD_OP,
    input  logic [3:0] CMD_DATA,
    input  logic [2:0] CMD_CNT,
    input  logic       CMD_SIN,
    input  logic [3:0] REG_Q,
    output logic [1:0] REG_S,
    output logic [3:0] REG_DI,
    output logic       REG_SL_SER,
    output logic       REG_SR_SER,
    output logic       REG_CLR_N,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] RESULT,
    output logic       ERR
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROTL  = 3'b100,
        OP_ROTR  = 3'b101,
        OP_CLEAR = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXEC    = 2'b01,
        ST_CAPTURE = 2'b10
    } state_e;

    // Register mode pin encodings
    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_UP   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_DOWN = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

    // Number of clocked register steps an opcode needs
    function automatic logic [CNT_W-1:0] step_count(input op_e op, input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] n;
        n = '0;
        case (op)
            OP_LOAD, OP_CLEAR:               n = CNT_W'(1);
            OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: n = cnt;
            default:                          n = '0;
        endcase
        return n;
    endfunction

    // Register mode pins used while an opcode is executing
    function automatic logic [MODE_W-1:0] op_mode(input op_e op);
        logic [MODE_W-1:0] m;
        m = MODE_HOLD;
        case (op)
            OP_LOAD:          m = MODE_LOAD;
            OP_SHL, OP_ROTL:  m = MODE_UP;
            OP_SHR, OP_ROTR:  m = MODE_DOWN;
            default:          m = MODE_HOLD;
        endcase
        return m;
    endfunction

    state_e              state, state_d;
    op_e                 op_q, op_d;
    logic                sin_q, sin_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [MODE_W-1:0]   s_d;
    logic [DATA_W-1:0]   di_d;
    logic                clr_n_d;
    logic                done_d;
    logic                err_d;
    logic [DATA_W-1:0]   result_d;
    op_e                 cmd_op;
    logic [CNT_W-1:0]    cmd_steps;

    assign cmd_op    = op_e'(CMD_OP);
    assign cmd_steps = step_count(cmd_op, CMD_CNT);

    // Handshake and status decode straight from the state register
    assign CMD_READY = (state == ST_IDLE);
    assign BUSY      = (state != ST_IDLE);

    // Serial fill: rotates recirculate the outgoing bit, shifts use the latched fill bit
    assign REG_SL_SER = (op_q == OP_ROTL) ? REG_Q[DATA_W-1] : sin_q;
    assign REG_SR_SER = (op_q == OP_ROTR) ? REG_Q[0]        : sin_q;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        op_d     = op_q;
        sin_d    = sin_q;
        rem_d    = rem_q;
        s_d      = REG_S;
        di_d     = REG_DI;
        clr_n_d  = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = RESULT;

        case (state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    op_d  = cmd_op;
                    sin_d = CMD_SIN;
                    rem_d = cmd_steps;
                    if (cmd_op == OP_LOAD) begin
                        di_d = CMD_DATA;
                    end
                    if (cmd_steps == '0) begin
                        // Nothing to clock into the register; report current Q
                        state_d = ST_CAPTURE;
                        s_d     = MODE_HOLD;
                        err_d   = (cmd_op == OP_RSVD);
                    end else begin
                        state_d = ST_EXEC;
                        s_d     = op_mode(cmd_op);
                        clr_n_d = (cmd_op != OP_CLEAR);
                    end
                end
            end

            ST_EXEC: begin
                // Each edge in EXEC performs one register step; the last one returns to hold
                if (rem_q <= CNT_W'(1)) begin
                    rem_d   = '0;
                    s_d     = MODE_HOLD;
                    state_d = ST_CAPTURE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end

            ST_CAPTURE: begin
                result_d = REG_Q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                s_d     = MODE_HOLD;
            end
        endcase
    end

    // State and registered outputs; reset abandons any command and clears the register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            sin_q     <= 1'b0;
            rem_q     <= '0;
            REG_S     <= MODE_HOLD;
            REG_DI    <= '0;
            REG_CLR_N <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            RESULT    <= '0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            sin_q     <= sin_d;
            rem_q     <= rem_d;
            REG_S     <= s_d;
            REG_DI    <= di_d;
            REG_CLR_N <= clr_n_d;
            DONE      <= done_d;
            ERR       <= err_d;
            RESULT    <= result_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_74194_ctrl.sv
// Bench for shift_reg_74194_ctrl: drives commands into the controller, which
// is attached to a behavioural 74194 register. Results are compared against
// an arithmetic model of each operation.
module tb_shift_reg_74194_ctrl;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP;
    logic [3:0] CMD_DATA;
    logic [2:0] CMD_CNT;
    logic       CMD_SIN;
    logic [3:0] REG_Q;
    logic [1:0] REG_S;
    logic [3:0] REG_DI;
    logic       REG_SL_SER;
    logic       REG_SR_SER;
    logic       REG_CLR_N;
    logic       BUSY;
    logic       DONE;
    logic [3:0] RESULT;
    logic       ERR;

    int checks   = 0;
    int failures = 0;
    logic [3:0] q_exp;

    shift_reg_74194_ctrl dut (
        .CLK(CLK), .CLR(CLR),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_CNT(CMD_CNT), .CMD_SIN(CMD_SIN),
        .REG_Q(REG_Q), .REG_S(REG_S), .REG_DI(REG_DI),
        .REG_SL_SER(REG_SL_SER), .REG_SR_SER(REG_SR_SER), .REG_CLR_N(REG_CLR_N),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // The attached 74194 register
    always @(posedge CLK) begin
        if (!REG_CLR_N)          REG_Q <= 4'b0000;
        else if (REG_S == 2'b01) REG_Q <= {REG_Q[2:0], REG_SL_SER};
        else if (REG_S == 2'b10) REG_Q <= {REG_SR_SER, REG_Q[3:1]};
        else if (REG_S == 2'b11) REG_Q <= REG_DI;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int steps_of(input logic [2:0] op, input logic [2:0] cnt);
        if (op == 3'd1 || op == 3'd6) return 1;
        if (op >= 3'd2 && op <= 3'd5) return int'(cnt);
        return 0;
    endfunction

    function automatic logic [1:0] mode_of(input logic [2:0] op);
        if (op == 3'd1) return 2'b11;
        if (op == 3'd2 || op == 3'd4) return 2'b01;
        if (op == 3'd3 || op == 3'd5) return 2'b10;
        return 2'b00;
    endfunction

    // Final register value of an operation, from whole-word arithmetic
    function automatic logic [3:0] model(input logic [3:0] q, input logic [2:0] op,
                                         input logic [3:0] data, input logic [2:0] cnt,
                                         input logic sin);
        int v;
        int qi;
        int n;
        int k;
        qi = int'(q);
        n  = int'(cnt);
        k  = n % 4;
        v  = qi;
        case (op)
            3'd1: v = int'(data);
            3'd2: v = (qi << n) | (sin ? ((1 << n) - 1) : 0);
            3'd3: v = (qi >> n) | (sin ? (15 & ~(15 >> n)) : 0);
            3'd4: v = (qi << k) | (qi >> (4 - k));
            3'd5: v = (qi >> k) | (qi << (4 - k));
            3'd6: v = 0;
            default: v = qi;
        endcase
        return 4'(v & 15);
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data,
                           input logic [2:0] cnt, input logic sin);
        int n;
        int k;
        int done_k;
        int err_k;
        logic [3:0] exp_q;
        n     = steps_of(op, cnt);
        exp_q = model(q_exp, op, data, cnt, sin);
        @(negedge CLK);
        CMD_OP = op; CMD_DATA = data; CMD_CNT = cnt; CMD_SIN = sin; CMD_VALID = 1'b1;
        k = 0;
        while (!CMD_READY && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check("ready_before_accept", 8'(CMD_READY), 8'd1);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        done_k = -1;
        err_k  = -1;
        for (int e = 0; e < 12 && done_k < 0; e++) begin
            @(negedge CLK);
            if (ERR)  err_k  = e;
            if (DONE) done_k = e;
            if (e == 0) begin
                check("busy_after_accept", 8'(BUSY), 8'd1);
                check("mode_after_accept", 8'(REG_S), 8'(n > 0 ? mode_of(op) : 2'b00));
                check("clr_n_after_accept", 8'(REG_CLR_N), 8'(op == 3'd6 ? 1'b0 : 1'b1));
                if (op == 3'd1) check("di_after_load", 8'(REG_DI), 8'(data));
            end
            if (n > 0 && e == n) check("q_after_last_step", 8'(REG_Q), 8'(exp_q));
            if (done_k < 0) @(posedge CLK);
        end
        check("done_latency", 8'(done_k), 8'(n + 1));
        check("err_pulse", 8'(err_k), 8'(op == 3'd7 ? 0 : -1));
        check("result", 8'(RESULT), 8'(exp_q));
        check("reg_q_final", 8'(REG_Q), 8'(exp_q));
        check("ready_with_done", 8'(CMD_READY), 8'd1);
        q_exp = exp_q;
    endtask

    initial begin
        int dcount;
        CLR = 1'b1; CMD_VALID = 1'b0; CMD_OP = 3'd0; CMD_DATA = 4'd0; CMD_CNT = 3'd0; CMD_SIN = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 8'(BUSY), 8'd0);
        check("rst_ready", 8'(CMD_READY), 8'd1);
        check("rst_s", 8'(REG_S), 8'd0);
        check("rst_di", 8'(REG_DI), 8'd0);
        check("rst_clr_n", 8'(REG_CLR_N), 8'd0);
        check("rst_done", 8'(DONE), 8'd0);
        check("rst_err", 8'(ERR), 8'd0);
        check("rst_result", 8'(RESULT), 8'd0);
        CLR = 1'b0;
        @(negedge CLK);
        check("rst_release_clr_n", 8'(REG_CLR_N), 8'd1);
        check("rst_reg_q", 8'(REG_Q), 8'd0);
        q_exp = 4'b0000;

        // Directed sequence
        run_cmd(3'd1, 4'b1010, 3'd0, 1'b0);
        run_cmd(3'd1, 4'b1001, 3'd0, 1'b0);
        run_cmd(3'd4, 4'b0000, 3'd1, 1'b0);
        run_cmd(3'd5, 4'b0000, 3'd2, 1'b0);
        run_cmd(3'd1, 4'b0000, 3'd0, 1'b0);
        run_cmd(3'd2, 4'b0000, 3'd3, 1'b1);
        run_cmd(3'd3, 4'b0000, 3'd2, 1'b0);
        run_cmd(3'd1, 4'b1111, 3'd0, 1'b0);
        run_cmd(3'd6, 4'b0000, 3'd0, 1'b0);
        run_cmd(3'd7, 4'b0101, 3'd3, 1'b1);
        run_cmd(3'd0, 4'b0101, 3'd5, 1'b1);
        run_cmd(3'd1, 4'b1011, 3'd0, 1'b0);
        run_cmd(3'd4, 4'b0000, 3'd0, 1'b1);
        run_cmd(3'd4, 4'b0000, 3'd4, 1'b0);
        run_cmd(3'd3, 4'b0000, 3'd7, 1'b1);

        // Reset in the middle of a long shift, with a command also offered
        run_cmd(3'd1, 4'b1101, 3'd0, 1'b0);
        @(negedge CLK);
        CMD_OP = 3'd3; CMD_CNT = 3'd7; CMD_SIN = 1'b1; CMD_VALID = 1'b1;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b1; CMD_VALID = 1'b1; CMD_OP = 3'd1; CMD_DATA = 4'b1111;
        @(negedge CLK);
        check("midrst_busy", 8'(BUSY), 8'd0);
        check("midrst_s", 8'(REG_S), 8'd0);
        check("midrst_clr_n", 8'(REG_CLR_N), 8'd0);
        check("midrst_di", 8'(REG_DI), 8'd0);
        check("midrst_result", 8'(RESULT), 8'd0);
        CLR = 1'b0; CMD_VALID = 1'b0;
        @(negedge CLK);
        check("midrst_reg_q", 8'(REG_Q), 8'd0);
        check("midrst_clr_n_back", 8'(REG_CLR_N), 8'd1);
        check("midrst_ready", 8'(CMD_READY), 8'd1);
        dcount = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE) dcount++;
        end
        check("midrst_no_done", 8'(dcount), 8'd0);
        q_exp = 4'b0000;

        // Back-to-back: valid held high across two commands
        @(negedge CLK);
        CMD_OP = 3'd1; CMD_DATA = 4'b0110; CMD_CNT = 3'd0; CMD_SIN = 1'b0; CMD_VALID = 1'b1;
        @(posedge CLK);
        #1 CMD_OP = 3'd5; CMD_CNT = 3'd4;
        repeat (3) @(negedge CLK);
        check("b2b_first_done", 8'(DONE), 8'd1);
        check("b2b_first_ready", 8'(CMD_READY), 8'd1);
        check("b2b_first_result", 8'(RESULT), 8'b0110);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        check("b2b_second_busy", 8'(BUSY), 8'd1);
        check("b2b_second_not_done", 8'(DONE), 8'd0);
        @(negedge CLK);
        check("b2b_second_done", 8'(DONE), 8'd1);
        check("b2b_second_result", 8'(RESULT), 8'b0110);
        q_exp = 4'b0110;

        // Randomized commands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 4'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_74194_ctrl.md
# shift_reg_74194_ctrl

Command sequencer for the 4-bit bidirectional shift register `shift_reg_74194`. It accepts one operation at a time over a valid/ready handshake: load, shift, rotate, clear or no-op. It drives the register's S, DI, SR_SER, SL_SER and CLR pins for the required number of cycles, then reports the final Q. It sits between a host/test controller and one register instance, and both share CLK.

## Interface
Parameters: none (register width fixed at 4, count field fixed at 3 bits).

Ports:
- CLK  in  1  clock; the register instance uses the same clock
- CLR  in  1  reset; synchronous, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  controller can accept a command; equals (state==IDLE)
- CMD_OP  in  3  000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 CLEAR, 111 reserved
- CMD_DATA  in  4  LOAD value
- CMD_CNT  in  3  shift/rotate step count, 0..7
- CMD_SIN  in  1  fill bit for SHL/SHR
- REG_Q  in  4  register Q output
- REG_S  out  2  register mode: 00 hold; 01 shift toward MSB with SL_SER into bit 0; 10 shift toward LSB with SR_SER into bit 3; 11 parallel load
- REG_DI  out  4  register parallel data
- REG_SL_SER  out  1  bit-0 fill for S=01
- REG_SR_SER  out  1  bit-3 fill for S=10
- REG_CLR_N  out  1  register clear, active-low
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle completion pulse
- RESULT  out  4  REG_Q captured at completion
- ERR  out  1  one-cycle pulse: reserved opcode was accepted

## Operation
- States: IDLE, EXEC, CAPTURE. The state register, REG_S, REG_DI, REG_CLR_N, DONE, RESULT and ERR are registered.
- Accept: CMD_VALID && CMD_READY at a rising edge. The op, count and SIN are latched, and REG_DI<=CMD_DATA for LOAD.
- Per-op step count N:
  - LOAD = 1, CLEAR = 1.
  - SHL, SHR, ROTL, ROTR = CMD_CNT.
  - NOP and reserved = 0.
- N=0: go directly to CAPTURE with REG_S=00. Reserved opcode additionally sets ERR=1 for one cycle.
- N>0: go to EXEC, with REG_S set to the op mode on the accept edge. Mode per op:
  - LOAD: 11.
  - SHL/ROTL: 01.
  - SHR/ROTR: 10.
  - CLEAR: REG_S=00 and REG_CLR_N=0.
- EXEC: the remaining count decrements each edge. At the edge where the remaining count is 1: REG_S<=00, REG_CLR_N<=1, go to CAPTURE.
- Serial fill (combinational from latched op):
  - REG_SL_SER = ROTL ? REG_Q[3] : latched SIN.
  - REG_SR_SER = ROTR ? REG_Q[0] : latched SIN.
- CAPTURE: RESULT<=REG_Q, DONE<=1, go to IDLE.
- REG_DI holds its last loaded value outside LOAD.
- Counts: rotate by 4 returns the original value; rotate/shift 5..7 are valid and proceed step by step.
- Commands presented while BUSY are held off (CMD_READY=0). The host must keep CMD_* stable until acceptance.

## Timing
- With accept edge = cycle 0, the register has the final Q after edge N. DONE is high during cycle N+2 (NOP: cycle 2). CMD_READY is high in that same cycle, so a back-to-back accept is allowed with no dead cycle.
- REG_S changes only on edges.
- Reset (CLR high at an edge) gives, in the next cycle:
  - state IDLE
  - REG_S=00, REG_DI=0000, REG_CLR_N=0
  - DONE=0, ERR=0, RESULT=0000, BUSY=0
- REG_CLR_N returns to 1 on the first edge with CLR low.
- Reset mid-operation: the command is abandoned, no DONE is issued, and the register is cleared via REG_CLR_N.
- CLR and CMD_VALID together: reset wins and no command is accepted.

## Test plan
- Reset, then LOAD 1010 → REG_Q=1010 after edge 1; DONE and RESULT=1010 in cycle 3.
- LOAD 1001, then ROTL cnt=1 → RESULT 0011; then ROTR cnt=2 → RESULT 1100.
- LOAD 0000, then SHL cnt=3 SIN=1 → RESULT 0111, DONE in cycle 5. Then SHR cnt=2 SIN=0 → RESULT 0001.
- LOAD 1111, then CLEAR → RESULT 0000. Then op 111 → ERR pulse, DONE in cycle 2, RESULT 0000, REG_Q unchanged.
- SHR cnt=7 accepted, CLR high at cycle 3 → no DONE, REG_Q=0000, CMD_READY=1 after reset deasserts.
- CMD_VALID held high with LOAD 0110 then ROTR cnt=4 → second command accepted in the first command's DONE cycle; RESULT 0110.
